bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Slot-based bus owner arbitration (ADMA > DMA > CPU) with a saturating CPU-stall counter.
// Optional CPU fairness (forced CPU slot after BURST_MAX non-CPU slots): define SV_ARB_CPU_FAIRNESS_EN.
module bus_arbiter #(
   parameter int BURST_MAX = 16,
   parameter int CNT_W     = 5
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        slot_ce,
   input  logic        adma_req,
   input  logic        dma_req,
   output logic [1:0]  owner,
   output logic        cpu_ce_en,
   output logic        dma_grant,
   output logic        adma_grant,
   output logic        adma_ack,
   input  logic        stall_clr,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0] OWN_CPU  = 2'b00;
   localparam logic [1:0] OWN_DMA  = 2'b01;
   localparam logic [1:0] OWN_ADMA = 2'b10;

   if (BURST_MAX < 1 || BURST_MAX >= (1 << CNT_W)) begin : g_bad_cfg
      $error("bus_arbiter: BURST_MAX must be 1..2**CNT_W-1");
   end

`ifdef SV_ARB_CPU_FAIRNESS_EN
   typedef enum logic [1:0] {ST_CPU, ST_DMA, ST_ADMA, ST_FORCE} state_t;
`else
   typedef enum logic [1:0] {ST_CPU, ST_DMA, ST_ADMA} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic        adma_ack_q, adma_ack_d;
   logic [15:0] stall_q, stall_d;
   logic        adma_want;

`ifdef SV_ARB_CPU_FAIRNESS_EN
   // An ADMA request seen on a forced CPU boundary is held until the next boundary.
   logic [CNT_W-1:0] burst_q, burst_d;
   logic             adma_pend_q, adma_pend_d;
   logic             force_slot;

   assign adma_want  = adma_req | adma_pend_q;
   assign force_slot = (burst_q == CNT_W'(BURST_MAX));

   always_comb begin
      burst_d     = burst_q;
      adma_pend_d = adma_pend_q;
      if (slot_ce) begin
         if (force_slot) begin
            burst_d     = '0;
            adma_pend_d = adma_want;
         end else begin
            adma_pend_d = 1'b0;
            burst_d     = (state_d == ST_CPU) ? '0 : burst_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         burst_q     <= '0;
         adma_pend_q <= 1'b0;
      end else begin
         burst_q     <= burst_d;
         adma_pend_q <= adma_pend_d;
      end
   end
`else
   assign adma_want = adma_req;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= ST_CPU;
         owner_q    <= OWN_CPU;
         adma_ack_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         adma_ack_q <= adma_ack_d;
         stall_q    <= stall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (slot_ce) begin
         if (adma_want)    state_d = ST_ADMA;
         else if (dma_req) state_d = ST_DMA;
         else              state_d = ST_CPU;
`ifdef SV_ARB_CPU_FAIRNESS_EN
         if (force_slot)   state_d = ST_FORCE;
`endif
      end
   end

   always_comb begin
      owner_d    = owner_q;
      adma_ack_d = 1'b0;
      if (slot_ce) begin
         case (state_d)
            ST_DMA:  owner_d = OWN_DMA;
            ST_ADMA: begin
               owner_d    = OWN_ADMA;
               adma_ack_d = 1'b1;
            end
            default: owner_d = OWN_CPU;
         endcase
      end
   end

   // Stall count is charged to the slot that is ending; a clear always wins.
   always_comb begin
      stall_d = stall_q;
      if (stall_clr)
         stall_d = '0;
      else if (slot_ce && owner_q != OWN_CPU && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   assign owner      = owner_q;
   assign cpu_ce_en  = (owner_q == OWN_CPU);
   assign dma_grant  = (owner_q == OWN_DMA);
   assign adma_grant = (owner_q == OWN_ADMA);
   assign adma_ack   = adma_ack_q;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random slots against a slot-level model.
module tb_bus_arbiter;

   localparam int BURST = 4;
`ifdef SV_ARB_CPU_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        slot_ce = 1'b0;
   logic        adma_req = 1'b0;
   logic        dma_req = 1'b0;
   logic        stall_clr = 1'b0;
   logic [1:0]  owner;
   logic        cpu_ce_en, dma_grant, adma_grant, adma_ack;
   logic [15:0] stall_cnt;
   logic [21:0] obs;

   int checks = 0;
   int failures = 0;

   // slot-level reference state
   logic [1:0] m_owner = 2'b00;
   bit         m_ack = 1'b0;
   bit         m_pend = 1'b0;
   int         m_run = 0;
   int         m_stall = 0;

   localparam logic [21:0] RESET_VEC = {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};

   always #5 clk = ~clk;

   bus_arbiter #(.BURST_MAX(BURST), .CNT_W(5)) dut (
      .clk_sys(clk), .reset(reset), .slot_ce(slot_ce), .adma_req(adma_req),
      .dma_req(dma_req), .owner(owner), .cpu_ce_en(cpu_ce_en), .dma_grant(dma_grant),
      .adma_grant(adma_grant), .adma_ack(adma_ack), .stall_clr(stall_clr),
      .stall_cnt(stall_cnt)
   );

   assign obs = {owner, cpu_ce_en, dma_grant, adma_grant, adma_ack, stall_cnt};

   function automatic logic [21:0] exp_vec();
      return {m_owner, (m_owner == 2'd0), (m_owner == 2'd1), (m_owner == 2'd2), m_ack,
              16'(m_stall)};
   endfunction

   task automatic model_reset();
      m_owner = 2'b00; m_ack = 1'b0; m_pend = 1'b0; m_run = 0; m_stall = 0;
   endtask

   // One bus slot boundary: charge the ending slot, then pick the new owner.
   task automatic model_slot(input bit a, input bit d, input bit clr);
      bit want;
      if (clr) m_stall = 0;
      else if (m_owner != 2'd0 && m_stall < 65535) m_stall = m_stall + 1;
      want = a || m_pend;
      if (FAIR && m_run >= BURST) begin
         m_owner = 2'd0; m_pend = want; m_run = 0;
      end else begin
         m_pend  = 1'b0;
         m_owner = want ? 2'd2 : (d ? 2'd1 : 2'd0);
         m_run   = (m_owner == 2'd0) ? 0 : m_run + 1;
      end
      m_ack = (m_owner == 2'd2);
   endtask

   // Pulse slot_ce with the given requests; returns at the negedge after the granting edge.
   task automatic do_slot(input bit a, input bit d, input bit clr);
      @(negedge clk);
      adma_req = a; dma_req = d; stall_clr = clr; slot_ce = 1'b1;
      @(negedge clk);
      slot_ce = 1'b0; stall_clr = 1'b0; adma_req = 1'b0;
      model_slot(a, d, clr);
   endtask

   task automatic test_reset();
      reset = 1'b1; adma_req = 1'b1; dma_req = 1'b1;
      repeat (2) begin
         @(negedge clk); slot_ce = 1'b1;
         @(negedge clk); slot_ce = 1'b0;
      end
      checks++;
      if (obs !== RESET_VEC) begin
         failures++; $display("FAIL reset_state: got %h expected %h", obs, RESET_VEC);
      end
      @(negedge clk); reset = 1'b0; adma_req = 1'b0; dma_req = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         do_slot(1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== RESET_VEC) begin
            failures++; $display("FAIL idle_slot%0d: got %h expected %h", i, obs, RESET_VEC);
         end
      end
   endtask

   task automatic test_dma_burst();
      int grants = 0;
      int exp_stall = FAIR ? 4 : 5;
      do_slot(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         do_slot(1'b0, 1'b1, 1'b0);
         if (dma_grant) grants++;
         checks++;
         if (obs !== exp_vec()) begin
            failures++; $display("FAIL dma_slot%0d: got %h expected %h", i, obs, exp_vec());
         end
      end
      do_slot(1'b0, 1'b0, 1'b0);
      checks++;
      if (owner !== 2'b00 || stall_cnt !== 16'(exp_stall) || grants != (FAIR ? 4 : 5)) begin
         failures++;
         $display("FAIL dma_burst_end: got owner=%0d stall=%0d grants=%0d expected owner=0 stall=%0d",
                  owner, stall_cnt, grants, exp_stall);
      end
   endtask

   task automatic test_adma_preempt();
      int acks = 0;
      logic [1:0] exp_pat [5];
      exp_pat = '{2'd1, 2'd1, 2'd2, 2'd1, FAIR ? 2'd0 : 2'd1};
      do_slot(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         do_slot(i == 2, 1'b1, 1'b0);
         if (adma_ack) acks++;
         checks++;
         if (owner !== exp_pat[i] || obs !== exp_vec()) begin
            failures++;
            $display("FAIL preempt_slot%0d: got %h expected %h (owner %0d)", i, obs, exp_vec(),
                     exp_pat[i]);
         end
         @(negedge clk);
         checks++;
         if (adma_ack !== 1'b0 || owner !== m_owner) begin
            failures++;
            $display("FAIL preempt_hold%0d: got ack=%b owner=%0d expected ack=0 owner=%0d",
                     i, adma_ack, owner, m_owner);
         end
      end
      checks++;
      if (acks != 1) begin
         failures++; $display("FAIL preempt_acks: got %0d expected 1", acks);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_pat [12];
      for (int i = 0; i < 12; i++) exp_pat[i] = (FAIR && (i == 4 || i == 9)) ? 2'd0 : 2'd1;
      do_slot(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         do_slot(1'b0, 1'b1, 1'b0);
         checks++;
         if (owner !== exp_pat[i] || obs !== exp_vec()) begin
            failures++;
            $display("FAIL fair_slot%0d: got owner=%0d vec=%h expected owner=%0d vec=%h",
                     i, owner, obs, exp_pat[i], exp_vec());
         end
      end
      do_slot(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_saturation();
      do_slot(1'b0, 1'b0, 1'b1);
      do_slot(1'b0, 1'b1, 1'b0);
      do_slot(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr = 1'b0; m_stall = 0;
      checks++;
      if (stall_cnt !== 16'h0000) begin
         failures++; $display("FAIL stall_clr_idle: got %h expected 0000", stall_cnt);
      end
      do_slot(1'b0, 1'b0, 1'b1);
      do_slot(1'b0, 1'b1, 1'b0);
      force dut.stall_q = 16'hFFFE;
      #1;
      release dut.stall_q;
      m_stall = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         do_slot(1'b0, 1'b1, 1'b0);
         checks++;
         if (obs !== exp_vec()) begin
            failures++; $display("FAIL sat_slot%0d: got %h expected %h", i, obs, exp_vec());
         end
      end
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
         failures++; $display("FAIL sat_hold: got %h expected FFFF", stall_cnt);
      end
      do_slot(1'b0, 1'b1, 1'b1);
      checks++;
      if (stall_cnt !== 16'h0000 || obs !== exp_vec()) begin
         failures++; $display("FAIL clr_wins: got %h expected stall 0000 vec %h", stall_cnt, exp_vec());
      end
   endtask

   task automatic test_reset_mid_burst();
      do_slot(1'b0, 1'b0, 1'b1);
      do_slot(1'b0, 1'b1, 1'b0);
      do_slot(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      adma_req = 1'b1; dma_req = 1'b1; reset = 1'b1; slot_ce = 1'b1;
      @(negedge clk);
      slot_ce = 1'b0;
      checks++;
      if (obs !== RESET_VEC) begin
         failures++; $display("FAIL midreset_edge: got %h expected %h", obs, RESET_VEC);
      end
      @(negedge clk); slot_ce = 1'b1;
      @(negedge clk); slot_ce = 1'b0;
      checks++;
      if (obs !== RESET_VEC) begin
         failures++; $display("FAIL midreset_ce_ignored: got %h expected %h", obs, RESET_VEC);
      end
      reset = 1'b0;
      model_reset();
      do_slot(1'b1, 1'b1, 1'b0);
      checks++;
      if (owner !== 2'd2 || adma_ack !== 1'b1 || obs !== exp_vec()) begin
         failures++; $display("FAIL midreset_adma: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      bit d = 1'b0;
      bit a, clr;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) d = ~d;
         a   = ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 19) == 0);
         do_slot(a, d, clr);
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL rand_slot%0d: a=%b d=%b got %h expected %h", i, a, d, obs, exp_vec());
         end
         repeat ($urandom_range(1, 2)) @(negedge clk);
         checks++;
         if (adma_ack !== 1'b0 || owner !== m_owner) begin
            failures++;
            $display("FAIL rand_hold%0d: got ack=%b owner=%0d expected ack=0 owner=%0d",
                     i, adma_ack, owner, m_owner);
         end
      end
   endtask

   initial begin
      test_reset();
      test_dma_burst();
      test_adma_preempt();
      test_fairness();
      test_saturation();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
